numa_mem_router: RTL and testbench

- Memory-side stage sitting directly below the multicycle MIPS core inside topmulti.
- Takes each core load/store and decodes the address node bit:
  - local node: access goes to the local RAM port with a fixed LOCAL_LAT latency.
  - remote node: access waits REMOTE_LAT link-delay cycles, then goes out on the inter-node request/acknowledge port.
- Returns read data with a one-cycle ready pulse.
- Keeps saturating local and remote access counters for NUMA statistics.

---
 rtl/numa_mem_router_if.sv | 37 +++
 rtl/numa_mem_router.sv | 126 ++++++++++++
 tb/tb_numa_mem_router.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/numa_mem_router_if.sv
// numa_mem_router_if: core, local-RAM and inter-node signals of the NUMA memory router
//   master : router view (accepts core requests, drives local RAM and remote link)
//   slave  : environment view (core plus both memories)
interface numa_mem_router_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              loc_en;
    logic              loc_we;
    logic [ADDR_W-1:0] loc_addr;
    logic [DATA_W-1:0] loc_wdata;
    logic [DATA_W-1:0] loc_rdata;
    logic              rem_req;
    logic              rem_we;
    logic [ADDR_W-1:0] rem_addr;
    logic [DATA_W-1:0] rem_wdata;
    logic              rem_ack;
    logic [DATA_W-1:0] rem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, loc_rdata, rem_ack, rem_rdata,
        output cpu_ready, cpu_rdata, loc_en, loc_we, loc_addr, loc_wdata,
               rem_req, rem_we, rem_addr, rem_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, loc_rdata, rem_ack, rem_rdata,
        input  cpu_ready, cpu_rdata, loc_en, loc_we, loc_addr, loc_wdata,
               rem_req, rem_we, rem_addr, rem_wdata
    );
endinterface

// File: rtl/numa_mem_router.sv
// numa_mem_router: routes core loads/stores to local RAM or the remote link by address node bit
//   CLOCK_50   : clock, rising edge
//   reset      : asynchronous active-low reset
//   bus        : core request/ready, local RAM port, remote request/ack port
//   local_cnt  : saturating count of completed local accesses
//   remote_cnt : saturating count of completed remote accesses
module numa_mem_router #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NODE_BIT   = 12,
    parameter int NODE_ID    = 0,
    parameter int LOCAL_LAT  = 1,
    parameter int REMOTE_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    numa_mem_router_if.master      bus,
    output logic [CNT_W-1:0]       local_cnt,
    output logic [CNT_W-1:0]       remote_cnt
);
    localparam int   LAT_MAX = LOCAL_LAT > REMOTE_LAT ? LOCAL_LAT : REMOTE_LAT;
    localparam int   CW      = $clog2(LAT_MAX + 1);
    localparam logic NODE_L  = 1'(NODE_ID);

    typedef enum logic [2:0] {IDLE, LOC_ACC, REM_DLY, REM_WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  loc_cnt_q, loc_cnt_d;
    logic [CNT_W-1:0]  rem_cnt_q, rem_cnt_d;

    assign local_cnt  = loc_cnt_q;
    assign remote_cnt = rem_cnt_q;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            loc_cnt_q <= '0;
            rem_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            loc_cnt_q <= loc_cnt_d;
            rem_cnt_q <= rem_cnt_d;
        end
    end

    // Outputs decode from state_q only, so an asynchronous reset drops them at once.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        loc_cnt_d     = loc_cnt_q;
        rem_cnt_d     = rem_cnt_q;
        bus.cpu_ready = 1'b0;
        bus.cpu_rdata = '0;
        bus.loc_en    = 1'b0;
        bus.loc_we    = 1'b0;
        bus.loc_addr  = '0;
        bus.loc_wdata = '0;
        bus.rem_req   = 1'b0;
        bus.rem_we    = 1'b0;
        bus.rem_addr  = '0;
        bus.rem_wdata = '0;
        case (state_q)
            IDLE: if (bus.cpu_req) begin
                we_d    = bus.cpu_we;
                addr_d  = bus.cpu_addr;
                wdata_d = bus.cpu_wdata;
                state_d = bus.cpu_addr[NODE_BIT] == NODE_L ? LOC_ACC : REM_DLY;
                cnt_d   = bus.cpu_addr[NODE_BIT] == NODE_L ? CW'(LOCAL_LAT - 1) : CW'(REMOTE_LAT - 1);
            end
            LOC_ACC: begin
                bus.loc_en    = 1'b1;
                // the counter still holds its load value only in the first cycle
                bus.loc_we    = we_q && cnt_q == CW'(LOCAL_LAT - 1);
                bus.loc_addr  = addr_q;
                bus.loc_wdata = wdata_q;
                cnt_d         = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    rdata_d = we_q ? '0 : bus.loc_rdata;
                end
            end
            REM_DLY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = REM_WAIT;
            end
            REM_WAIT: begin
                bus.rem_req   = 1'b1;
                bus.rem_we    = we_q;
                bus.rem_addr  = addr_q;
                bus.rem_wdata = wdata_q;
                if (bus.rem_ack) begin
                    state_d = DONE;
                    rdata_d = we_q ? '0 : bus.rem_rdata;
                end
            end
            DONE: begin
                bus.cpu_ready = 1'b1;
                bus.cpu_rdata = rdata_q;
                state_d       = IDLE;
                if (addr_q[NODE_BIT] == NODE_L) loc_cnt_d = &loc_cnt_q ? loc_cnt_q : loc_cnt_q + 1'b1;
                else rem_cnt_d = &rem_cnt_q ? rem_cnt_q : rem_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_numa_mem_router.sv
// tb_numa_mem_router: directed self-checking bench for numa_mem_router (CNT_W=4)
module tb_numa_mem_router;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] local_cnt, remote_cnt;
    int         n_chk = 0;
    int         n_fail = 0;

    numa_mem_router_if #(.ADDR_W(32), .DATA_W(32)) bus();

    numa_mem_router #(.CNT_W(4)) dut (
        .CLOCK_50  (clk),
        .reset     (rst_n),
        .bus       (bus),
        .local_cnt (local_cnt),
        .remote_cnt(remote_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.loc_rdata = '0;
        bus.rem_ack   = 1'b0;
        bus.rem_rdata = '0;
        repeat (3) step();
        chk("rst_ready", 32'(bus.cpu_ready), 0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        chk("rst_loc_en", 32'(bus.loc_en), 0);
        chk("rst_rem_req", 32'(bus.rem_req), 0);
        chk("rst_local_cnt", 32'(local_cnt), 0);
        chk("rst_remote_cnt", 32'(remote_cnt), 0);
        rst_n = 1'b1;
        repeat (2) step();
        chk("idle_loc_en", 32'(bus.loc_en), 0);

        // local load
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40; bus.loc_rdata = 32'hDEADBEEF;
        step();
        bus.cpu_req = 1'b0; bus.cpu_addr = 32'h1FFC;
        chk("ll_loc_en", 32'(bus.loc_en), 1);
        chk("ll_loc_we", 32'(bus.loc_we), 0);
        chk("ll_loc_addr", bus.loc_addr, 32'h40);
        chk("ll_ready_early", 32'(bus.cpu_ready), 0);
        step();
        chk("ll_ready", 32'(bus.cpu_ready), 1);
        chk("ll_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        chk("ll_loc_en_off", 32'(bus.loc_en), 0);
        step();
        chk("ll_ready_off", 32'(bus.cpu_ready), 0);
        chk("ll_rdata_off", bus.cpu_rdata, 0);
        chk("ll_local_cnt", 32'(local_cnt), 1);

        // local store
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h44; bus.cpu_wdata = 32'h12345678;
        step();
        bus.cpu_req = 1'b0; bus.cpu_wdata = 32'h0;
        chk("ls_loc_we", 32'(bus.loc_we), 1);
        chk("ls_loc_addr", bus.loc_addr, 32'h44);
        chk("ls_loc_wdata", bus.loc_wdata, 32'h12345678);
        step();
        chk("ls_loc_we_off", 32'(bus.loc_we), 0);
        chk("ls_ready", 32'(bus.cpu_ready), 1);
        chk("ls_rdata", bus.cpu_rdata, 0);
        step();
        chk("ls_local_cnt", 32'(local_cnt), 2);
        chk("ls_remote_cnt", 32'(remote_cnt), 0);

        // remote load, ack tied high
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1000;
        bus.rem_ack = 1'b1; bus.rem_rdata = 32'hCAFEF00D;
        step();
        bus.cpu_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("rl_dly%0d_req", i), 32'(bus.rem_req), 0);
            chk($sformatf("rl_dly%0d_loc_en", i), 32'(bus.loc_en), 0);
            step();
        end
        chk("rl_rem_req", 32'(bus.rem_req), 1);
        chk("rl_rem_addr", bus.rem_addr, 32'h1000);
        chk("rl_rem_we", 32'(bus.rem_we), 0);
        chk("rl_ready_early", 32'(bus.cpu_ready), 0);
        step();
        chk("rl_rem_req_off", 32'(bus.rem_req), 0);
        chk("rl_ready", 32'(bus.cpu_ready), 1);
        chk("rl_rdata", bus.cpu_rdata, 32'hCAFEF00D);
        bus.rem_ack = 1'b0;
        step();
        chk("rl_remote_cnt", 32'(remote_cnt), 1);
        chk("rl_local_cnt", 32'(local_cnt), 2);

        // remote store, early ack ignored, ack 3 cycles after rem_req
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h1234; bus.cpu_wdata = 32'h0000A5A5;
        bus.rem_rdata = 32'hFFFFFFFF;
        step();
        bus.cpu_req = 1'b0; bus.cpu_addr = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("rd_dly%0d_req", i), 32'(bus.rem_req), 0);
            bus.rem_ack = (i == 2);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rd_wait%0d_req", i), 32'(bus.rem_req), 1);
            chk($sformatf("rd_wait%0d_addr", i), bus.rem_addr, 32'h1234);
            chk($sformatf("rd_wait%0d_we", i), 32'(bus.rem_we), 1);
            chk($sformatf("rd_wait%0d_wdata", i), bus.rem_wdata, 32'h0000A5A5);
            chk($sformatf("rd_wait%0d_ready", i), 32'(bus.cpu_ready), 0);
            bus.rem_ack = (i == 3);
            step();
        end
        bus.rem_ack = 1'b0;
        chk("rd_ready", 32'(bus.cpu_ready), 1);
        chk("rd_rdata", bus.cpu_rdata, 0);
        chk("rd_rem_req_off", 32'(bus.rem_req), 0);
        step();
        chk("rd_remote_cnt", 32'(remote_cnt), 2);

        // back-to-back local loads, cpu_req held high; counter saturates
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h80; bus.loc_rdata = 32'h00000001;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("bb%0d_loc_en", i), 32'(bus.loc_en), 1);
            step();
            chk($sformatf("bb%0d_ready", i), 32'(bus.cpu_ready), 1);
            step();
            chk($sformatf("bb%0d_bubble", i), 32'(bus.loc_en | bus.cpu_ready), 0);
            if (i == 19) bus.cpu_req = 1'b0;
        end
        chk("bb_local_cnt_sat", 32'(local_cnt), 15);
        step();
        chk("bb_idle", 32'(bus.loc_en), 0);

        // reset during REM_WAIT
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h1000;
        step();
        bus.cpu_req = 1'b0;
        repeat (4) step();
        chk("ar_rem_req_pre", 32'(bus.rem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rem_req_async", 32'(bus.rem_req), 0);
        chk("ar_local_cnt", 32'(local_cnt), 0);
        chk("ar_remote_cnt", 32'(remote_cnt), 0);
        bus.rem_ack = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ar_no_ready%0d", i), 32'(bus.cpu_ready | bus.rem_req), 0);
            step();
        end
        bus.rem_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
